// File: rtl/alu_seq_unit.sv
// Execution stage: single-cycle logic ops, iterative shift-add MUL (WIDTH cycles in RUN).
// Results/flags registered and held until the next Done; Start is ignored while Busy.
module alu_seq_unit #(
  parameter int WIDTH = 17,
  parameter int OP_W  = 4,
  parameter int CNT_W = 5
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [OP_W-1:0]  OpCode,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Carry,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(2);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SLT = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SHL = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SHR = OP_W'(7);
  localparam logic [OP_W-1:0] OP_MUL = OP_W'(8);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 carry_q, carry_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       diff;
  logic [4:0]           sh_amt;
  logic                 sh_over;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_carry;
  logic [2*WIDTH-1:0]   acc_step;
  logic                 last_iter;

  // Single-cycle datapath works straight off the inputs; the result is captured at acceptance.
  always_comb begin
    sum       = {1'b0, OperandA} + {1'b0, OperandB};
    diff      = {1'b0, OperandA} - {1'b0, OperandB};
    sh_amt    = OperandB[4:0];
    sh_over   = (int'(sh_amt) >= WIDTH);
    alu_res   = '0;
    alu_carry = 1'b0;
    case (OpCode)
      OP_ADD: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
      end
      OP_SUB: begin
        alu_res   = diff[WIDTH-1:0];
        alu_carry = diff[WIDTH];
      end
      OP_AND:  alu_res = OperandA & OperandB;
      OP_OR:   alu_res = OperandA | OperandB;
      OP_XOR:  alu_res = OperandA ^ OperandB;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(OperandA) < $signed(OperandB))};
      OP_SHL:  alu_res = sh_over ? '0 : (OperandA << sh_amt);
      OP_SHR:  alu_res = sh_over ? '0 : (OperandA >> sh_amt);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    last_iter = (cnt_q == CNT_W'(1));
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          if (OpCode == OP_MUL) begin
            state_d  = S_RUN;
            mcand_d  = {{WIDTH{1'b0}}, OperandA};
            mplier_d = OperandB;
            acc_d    = '0;
            cnt_d    = CNT_W'(WIDTH);
          end else begin
            state_d  = S_DONE;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            carry_d  = alu_carry;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
        if (last_iter) begin
          state_d  = S_DONE;
          result_d = acc_step[WIDTH-1:0];
          zero_d   = (acc_step[WIDTH-1:0] == '0);
          carry_d  = |acc_step[2*WIDTH-1:WIDTH];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      carry_q  <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign Result = result_q;
  assign Zero   = zero_q;
  assign Carry  = carry_q;
  assign Busy   = (state_q == S_RUN);
  assign Done   = (state_q == S_DONE);

endmodule
